usb_bus_ctrl: RTL and testbench
===============================

Name: usb_bus_ctrl

Overview:
- Full-speed device bus-state controller placed beside usb_utm.
- Consumes the synchronized UTMI line state.
- Sequences the frontend pull-up and remote-wakeup K drive.
- Detects attach, bus reset, suspend and resume, and reports them to the SIE/PE as levels and pulses.

Parameters:
RESET_CYCLES, 120, consecutive SE0 cycles that qualify a bus reset (2.5 us at 48 MHz)
SUSPEND_CYCLES, 144000, consecutive J cycles that enter suspend (3 ms)
RWAKE_IDLE_CYCLES, 96000, cycles in SUSPEND before remote wakeup is allowed (total idle 5 ms)
RWAKE_DRIVE_CYCLES, 96000, cycles K is driven for remote wakeup (2 ms)
KFILT_CYCLES, 8, consecutive K cycles that qualify host resume (glitch filter)

Ports:
clk  input  1  system clock (48 MHz)
rst  input  1  synchronous reset, active-high
usb_en  input  1  software attach enable
rwake_en  input  1  remote wakeup enabled by host (SET_FEATURE)
rwake_req  input  1  single-cycle remote wakeup request
line_state  input  2  UTMI line state: 00 SE0, 01 J, 10 K, 11 SE1
pu  output  1  D+ pull-up enable to frontend
drive_k  output  1  request the UTM transmitter to hold K
bus_reset  output  1  single-cycle pulse on bus reset qualification
usb_reset  output  1  level, high from qualification until SE0 ends
suspend  output  1  level, high while in SUSPEND
resume  output  1  single-cycle pulse on return to ACTIVE from resume
bus_state  output  3  current state encoding (debug/status)

Behaviour:
- Reset is synchronous; rst=1 forces state DETACHED and clears all counters. All outputs are 0 and bus_state=DETACHED.
- States: DETACHED, ACTIVE, BUS_RESET, SUSPEND, RWAKE, RESUME. Encoding is fixed in the package.
- One shared duration counter, width $clog2 of the largest parameter plus 1. It clears on every state change and whenever the qualifying line condition breaks. It saturates at its maximum and never wraps.
- usb_en=0 in any state: next cycle DETACHED. Outputs deassert that cycle, including mid-RWAKE (drive_k drops).
- DETACHED: pu=0. usb_en=1 moves to ACTIVE next cycle; pu=1 from then on.
- ACTIVE:
  - SE0 held RESET_CYCLES consecutive cycles: go to BUS_RESET; bus_reset pulses in the same cycle as the transition.
  - J held SUSPEND_CYCLES consecutive cycles: go to SUSPEND.
  - K and SE1 clear both qualifications.
- BUS_RESET: usb_reset=1. The first non-SE0 cycle returns to ACTIVE, and usb_reset=0 in that cycle.
- SUSPEND:
  - suspend=1. The counter counts time in state independent of line state; a separate small counter counts consecutive K.
  - K for KFILT_CYCLES: go to RESUME.
  - SE0 for RESET_CYCLES: go to BUS_RESET with bus_reset pulse. Reset overrides resume if both qualify the same cycle.
  - rwake_req=1 with rwake_en=1 and time in state >= RWAKE_IDLE_CYCLES: go to RWAKE. Otherwise rwake_req is dropped and not latched.
- RWAKE: suspend=1 and drive_k=1 for exactly RWAKE_DRIVE_CYCLES cycles, then go to RESUME. The line state is ignored while driving.
- RESUME:
  - suspend=1 and drive_k=0.
  - J (end of host resume after its low-speed EOP) returns to ACTIVE; resume pulses on the transition cycle and suspend drops.
  - SE0 for RESET_CYCLES goes to BUS_RESET.
  - K or a short SE0 stays in RESUME.
- Simultaneous usb_en=0 with any other event: DETACHED wins.
- Latencies:
  - bus_reset asserts in the cycle the RESET_CYCLES-th SE0 sample is seen.
  - suspend asserts on the cycle after the SUSPEND_CYCLES-th J sample.

Decomposition:
- Add to usb_utmi_pkg:
  - line-state enum (SE0/J/K/SE1)
  - usb_bus_state_t enum
  - default timing localparams derived from a 48 MHz clock (2.5 us, 3 ms, 5 ms, 2 ms)
- Single module, no sub-module. The K glitch filter is small enough to stay inline.

Test Plan:
- Scaled parameters for all tests: RESET=12, SUSPEND=30, RWAKE_IDLE=20, RWAKE_DRIVE=16, KFILT=4.
- Attach: rst then usb_en=1 with J -> pu=1 one cycle later, bus_state=ACTIVE, no pulses. Clear usb_en -> pu=0 next cycle.
- Bus reset: 11 SE0 then J -> no reset. 12 SE0 -> bus_reset one pulse, usb_reset high until first J, ACTIVE after.
- Suspend/host resume: 30 J -> suspend=1. 3 K then J -> still SUSPEND. 4 K -> RESUME, then J -> resume pulse, suspend=0.
- Remote wakeup:
  - rwake_req at 10 cycles into SUSPEND -> ignored.
  - At 20 cycles with rwake_en=1 -> drive_k high exactly 16 cycles, then host K/SE0/J -> resume pulse.
  - rwake_en=0 -> no drive_k ever.
- Reset from suspend: 12 SE0 in SUSPEND -> bus_reset pulse, suspend=0, usb_reset=1.
- Mid-operation aborts: usb_en=0 during RWAKE cycle 5 -> drive_k=0 and DETACHED next cycle. rst during BUS_RESET -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// Shared UTMI-side types and default full-speed bus timing, for a 48 MHz clock.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        LsSe0 = 2'b00,
        LsJ   = 2'b01,
        LsK   = 2'b10,
        LsSe1 = 2'b11
    } usb_line_state_t;

    typedef enum logic [2:0] {
        StDetached = 3'd0,
        StActive   = 3'd1,
        StBusReset = 3'd2,
        StSuspend  = 3'd3,
        StRwake    = 3'd4,
        StResume   = 3'd5
    } usb_bus_state_t;

    // 2.5 us, 3 ms, 5 ms total idle minus the 3 ms suspend entry, 2 ms drive.
    localparam int unsigned DefResetCycles      = 120;
    localparam int unsigned DefSuspendCycles    = 144_000;
    localparam int unsigned DefRwakeIdleCycles  = 96_000;
    localparam int unsigned DefRwakeDriveCycles = 96_000;
    localparam int unsigned DefKfiltCycles      = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_bus_ctrl.sv
// Full-speed device bus-state controller: attach, bus reset, suspend,
// host resume and remote wakeup sequencing from the UTMI line state.
module usb_bus_ctrl
    import usb_utmi_pkg::*;
#(
    parameter int unsigned RESET_CYCLES       = DefResetCycles,
    parameter int unsigned SUSPEND_CYCLES     = DefSuspendCycles,
    parameter int unsigned RWAKE_IDLE_CYCLES  = DefRwakeIdleCycles,
    parameter int unsigned RWAKE_DRIVE_CYCLES = DefRwakeDriveCycles,
    parameter int unsigned KFILT_CYCLES       = DefKfiltCycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_en,
    input  logic       rwake_en,
    input  logic       rwake_req,
    input  logic [1:0] line_state,
    output logic       pu,
    output logic       drive_k,
    output logic       bus_reset,
    output logic       usb_reset,
    output logic       suspend,
    output logic       resume,
    output logic [2:0] bus_state
);

    localparam int unsigned MaxCycles = max_u(max_u(max_u(RESET_CYCLES, SUSPEND_CYCLES),
                                                    max_u(RWAKE_IDLE_CYCLES,
                                                          RWAKE_DRIVE_CYCLES)),
                                              KFILT_CYCLES);
    localparam int unsigned DurW = $clog2(MaxCycles) + 1;
    localparam int unsigned RunW = $clog2(max_u(RESET_CYCLES, KFILT_CYCLES)) + 1;

    localparam logic [DurW-1:0] ResetLim    = DurW'(RESET_CYCLES);
    localparam logic [DurW-1:0] SuspLim     = DurW'(SUSPEND_CYCLES);
    localparam logic [DurW-1:0] IdleLim     = DurW'(RWAKE_IDLE_CYCLES);
    localparam logic [DurW-1:0] DriveLast   = DurW'(RWAKE_DRIVE_CYCLES - 1);
    localparam logic [RunW-1:0] RunResetLim = RunW'(RESET_CYCLES);
    localparam logic [RunW-1:0] RunKfiltLim = RunW'(KFILT_CYCLES);

    usb_bus_state_t  state_q, state_d;
    usb_line_state_t ls, last_q;
    logic [DurW-1:0] dur_q, dur_d, dur_inc, dur_run;
    logic [RunW-1:0] run_q, run_d, run_inc, run_run;
    logic            same;

    assign ls      = usb_line_state_t'(line_state);
    assign same    = (ls == last_q);
    assign dur_inc = (dur_q == '1) ? dur_q : dur_q + 1'b1;
    assign run_inc = (run_q == '1) ? run_q : run_q + 1'b1;
    // Length of the current consecutive run of the same line state, this sample included.
    assign dur_run = same ? dur_inc : DurW'(1);
    assign run_run = same ? run_inc : RunW'(1);

    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        run_d     = '0;
        bus_reset = 1'b0;
        resume    = 1'b0;
        case (state_q)
            StDetached: begin
                dur_d = '0;
                if (usb_en) state_d = StActive;
            end
            StActive: begin
                case (ls)
                    LsSe0: begin
                        dur_d = dur_run;
                        if (dur_run >= ResetLim) begin
                            state_d   = StBusReset;
                            bus_reset = 1'b1;
                        end
                    end
                    LsJ: begin
                        dur_d = dur_run;
                        if (dur_run >= SuspLim) state_d = StSuspend;
                    end
                    default: dur_d = '0;
                endcase
            end
            StBusReset: begin
                if (ls != LsSe0) state_d = StActive;
            end
            StSuspend: begin
                // Shared counter measures idle time; the small one tracks SE0/K runs.
                dur_d = dur_inc;
                if (ls == LsSe0 || ls == LsK) run_d = run_run;
                if (ls == LsSe0 && run_run >= RunResetLim) begin
                    state_d   = StBusReset;
                    bus_reset = 1'b1;
                end else if (ls == LsK && run_run >= RunKfiltLim) begin
                    state_d = StResume;
                end else if (rwake_req && rwake_en && dur_q >= IdleLim) begin
                    state_d = StRwake;
                end
            end
            StRwake: begin
                dur_d = dur_inc;
                if (dur_q >= DriveLast) state_d = StResume;
            end
            StResume: begin
                if (ls == LsJ) begin
                    state_d = StActive;
                    resume  = 1'b1;
                end else if (ls == LsSe0) begin
                    dur_d = dur_run;
                    if (dur_run >= ResetLim) begin
                        state_d   = StBusReset;
                        bus_reset = 1'b1;
                    end
                end else begin
                    dur_d = '0;
                end
            end
            default: state_d = StDetached;
        endcase

        if (state_d != state_q) begin
            dur_d = '0;
            run_d = '0;
        end
        if (!usb_en) begin
            state_d   = StDetached;
            dur_d     = '0;
            run_d     = '0;
            bus_reset = 1'b0;
            resume    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDetached;
            dur_q   <= '0;
            run_q   <= '0;
            last_q  <= LsJ;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            run_q   <= run_d;
            last_q  <= ls;
        end
    end

    assign pu        = (state_q != StDetached);
    assign drive_k   = (state_q == StRwake);
    assign usb_reset = (state_q == StBusReset) && (ls == LsSe0);
    assign suspend   = (state_q inside {StSuspend, StRwake, StResume});
    assign bus_state = state_q;

endmodule

// File: tb/tb_usb_bus_ctrl.sv
// Bench for usb_bus_ctrl with scaled timing: vector table, directed corner cases
// and a randomized run against a cycle-level reference model of the bus rules.
module tb_usb_bus_ctrl;
    import usb_utmi_pkg::*;

    localparam int unsigned TR = 12, TS = 30, TI = 20, TD = 16, TK = 4;
    localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1, usb_en = 1'b0, rwake_en = 1'b0, rwake_req = 1'b0;
    logic [1:0] line_state = J;
    logic       pu, drive_k, bus_reset, usb_reset, suspend, resume;
    logic [2:0] bus_state;

    usb_bus_ctrl #(
        .RESET_CYCLES      (TR),
        .SUSPEND_CYCLES    (TS),
        .RWAKE_IDLE_CYCLES (TI),
        .RWAKE_DRIVE_CYCLES(TD),
        .KFILT_CYCLES      (TK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .usb_en    (usb_en),
        .rwake_en  (rwake_en),
        .rwake_req (rwake_req),
        .line_state(line_state),
        .pu        (pu),
        .drive_k   (drive_k),
        .bus_reset (bus_reset),
        .usb_reset (usb_reset),
        .suspend   (suspend),
        .resume    (resume),
        .bus_state (bus_state)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, cyc = 0;
    logic [8:0] got;

    // Reference model: state plus in-state run lengths and time in state.
    usb_bus_state_t m_st = StDetached;
    int m_se0 = 0, m_j = 0, m_k = 0, m_time = 0;

    function automatic logic [8:0] mk(logic p, logic dk, logic br, logic ur, logic sp,
                                      logic rs, usb_bus_state_t s);
        return {p, dk, br, ur, sp, rs, s};
    endfunction

    task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g === e) passed++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, g, e);
    endtask

    task automatic step(input logic r, input logic en, input logic wen, input logic req,
                        input logic [1:0] ls);
        usb_bus_state_t nx;
        logic br, rs;
        int se0_n, j_n, k_n;
        @(negedge clk);
        rst = r; usb_en = en; rwake_en = wen; rwake_req = req; line_state = ls;
        #1;
        se0_n = (ls == SE0) ? m_se0 + 1 : 0;
        j_n   = (ls == J)   ? m_j + 1   : 0;
        k_n   = (ls == K)   ? m_k + 1   : 0;
        nx = m_st; br = 1'b0; rs = 1'b0;
        case (m_st)
            StDetached: if (en) nx = StActive;
            StActive: begin
                if (se0_n >= TR) begin nx = StBusReset; br = 1'b1; end
                else if (j_n >= TS) nx = StSuspend;
            end
            StBusReset: if (ls != SE0) nx = StActive;
            StSuspend: begin
                if (se0_n >= TR) begin nx = StBusReset; br = 1'b1; end
                else if (k_n >= TK) nx = StResume;
                else if (req && wen && m_time >= TI) nx = StRwake;
            end
            StRwake: if (m_time + 1 >= TD) nx = StResume;
            StResume: begin
                if (ls == J) begin nx = StActive; rs = 1'b1; end
                else if (se0_n >= TR) begin nx = StBusReset; br = 1'b1; end
            end
            default: nx = StDetached;
        endcase
        if (!en) begin nx = StDetached; br = 1'b0; rs = 1'b0; end
        got = {pu, drive_k, bus_reset, usb_reset, suspend, resume, bus_state};
        if (!r)
            check("model", {23'd0, got},
                  {23'd0, mk(m_st != StDetached, m_st == StRwake, br,
                             m_st == StBusReset && ls == SE0,
                             m_st inside {StSuspend, StRwake, StResume}, rs, m_st)});
        @(posedge clk);
        cyc++;
        if (r || nx != m_st) begin
            m_st = r ? StDetached : nx;
            m_se0 = 0; m_j = 0; m_k = 0; m_time = 0;
        end else begin
            m_se0 = se0_n; m_j = j_n; m_k = k_n; m_time++;
        end
    endtask

    task automatic idle(input int n, input logic [1:0] ls);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, ls);
    endtask

    // Detach, re-attach, then exactly TS J samples; the next cycle is suspend cycle 0.
    task automatic to_suspend();
        step(1'b0, 1'b0, 1'b0, 1'b0, J);
        step(1'b0, 1'b0, 1'b0, 1'b0, J);
        idle(1 + TS, J);
    endtask

    typedef struct {
        logic       en;
        logic [1:0] ls;
        int         reps;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int dk_cnt;
        int n;
        tbl[0]  = '{1'b0, J,   1,  mk(0, 0, 0, 0, 0, 0, StDetached)};
        tbl[1]  = '{1'b1, J,   1,  mk(0, 0, 0, 0, 0, 0, StDetached)};
        tbl[2]  = '{1'b1, J,   1,  mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[3]  = '{1'b1, SE0, 11, mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[4]  = '{1'b1, J,   1,  mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[5]  = '{1'b1, SE0, 11, mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[6]  = '{1'b1, SE0, 1,  mk(1, 0, 1, 0, 0, 0, StActive)};
        tbl[7]  = '{1'b1, SE0, 3,  mk(1, 0, 0, 1, 0, 0, StBusReset)};
        tbl[8]  = '{1'b1, J,   1,  mk(1, 0, 0, 0, 0, 0, StBusReset)};
        tbl[9]  = '{1'b1, J,   1,  mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[10] = '{1'b1, J,   28, mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[11] = '{1'b1, J,   1,  mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[12] = '{1'b1, J,   1,  mk(1, 0, 0, 0, 1, 0, StSuspend)};
        tbl[13] = '{1'b1, K,   3,  mk(1, 0, 0, 0, 1, 0, StSuspend)};
        tbl[14] = '{1'b1, J,   1,  mk(1, 0, 0, 0, 1, 0, StSuspend)};
        tbl[15] = '{1'b1, K,   3,  mk(1, 0, 0, 0, 1, 0, StSuspend)};
        tbl[16] = '{1'b1, K,   1,  mk(1, 0, 0, 0, 1, 0, StSuspend)};
        tbl[17] = '{1'b1, K,   2,  mk(1, 0, 0, 0, 1, 0, StResume)};
        tbl[18] = '{1'b1, J,   1,  mk(1, 0, 0, 0, 1, 1, StResume)};
        tbl[19] = '{1'b1, J,   1,  mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[20] = '{1'b0, J,   1,  mk(1, 0, 0, 0, 0, 0, StActive)};
        tbl[21] = '{1'b0, J,   1,  mk(0, 0, 0, 0, 0, 0, StDetached)};

        step(1'b1, 1'b0, 1'b0, 1'b0, J);
        step(1'b1, 1'b0, 1'b0, 1'b0, J);
        for (int i = 0; i < 22; i++)
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(1'b0, tbl[i].en, 1'b0, 1'b0, tbl[i].ls);
                check($sformatf("table row %0d", i), {23'd0, got}, {23'd0, tbl[i].exp});
            end

        // Remote wakeup: early requests dropped, request at idle boundary accepted.
        to_suspend();
        idle(10, J);
        step(1'b0, 1'b1, 1'b1, 1'b1, J);             // suspend cycle 10
        idle(8, J);
        check("early rwake ignored", {29'd0, got[2:0]}, {29'd0, StSuspend});
        step(1'b0, 1'b1, 1'b1, 1'b1, J);             // cycle 19, still too early
        step(1'b0, 1'b1, 1'b1, 1'b1, J);             // cycle 20, accepted
        dk_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, (i % 3 == 0) ? SE0 : K);
            if (got[7]) dk_cnt++;
            else if (dk_cnt > 0) break;
        end
        check("drive_k length", dk_cnt, TD);
        check("resume state after drive", {29'd0, got[2:0]}, {29'd0, StResume});
        idle(3, SE0);
        step(1'b0, 1'b1, 1'b0, 1'b0, J);
        check("rwake resume pulse", {31'd0, got[3]}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, J);
        check("suspend drops", {31'd0, got[4]}, 32'd0);

        // rwake_en low: request well past idle time never drives K.
        to_suspend();
        idle(25, J);
        step(1'b0, 1'b1, 1'b0, 1'b1, J);
        dk_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, J);
            if (got[7]) dk_cnt++;
        end
        check("no drive without rwake_en", dk_cnt, 0);

        // Bus reset out of suspend.
        to_suspend();
        idle(TR - 1, SE0);
        step(1'b0, 1'b1, 1'b0, 1'b0, SE0);
        check("suspend reset pulse", {31'd0, got[6]}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, SE0);
        check("suspend reset level", {30'd0, got[5:4]}, 32'b10);

        // Detach in the middle of remote wakeup drive.
        to_suspend();
        idle(TI, J);
        step(1'b0, 1'b1, 1'b1, 1'b1, J);
        idle(5, J);
        step(1'b0, 1'b0, 1'b1, 1'b0, J);             // drive cycle 5
        step(1'b0, 1'b0, 1'b1, 1'b0, J);
        check("abort drive_k", {28'd0, got[7], got[2:0]}, {28'd0, 1'b0, StDetached});

        // Synchronous reset while in bus reset.
        step(1'b0, 1'b1, 1'b0, 1'b0, J);
        idle(TR + 2, SE0);
        step(1'b1, 1'b1, 1'b0, 1'b0, SE0);
        step(1'b0, 1'b1, 1'b0, 1'b0, SE0);
        check("rst in bus reset", {23'd0, got}, 32'd0);

        // Randomized runs of line states against the model.
        n = 0;
        while (n < 4000) begin
            int pick, len;
            logic [1:0] ls;
            logic wen;
            pick = $urandom_range(0, 19);
            ls = (pick < 8) ? J : (pick < 13) ? K : (pick < 18) ? SE0 : SE1;
            len = $urandom_range(1, 40);
            wen = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < len; i++) begin
                step($urandom_range(0, 799) == 0, $urandom_range(0, 299) != 0, wen,
                     $urandom_range(0, 24) == 0, ls);
                n++;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
